// File: rtl/xosera_bus_sequencer.sv
// Host-side master for the Xosera 8-bit register bus. Each 16-bit command is
// split into MSB then LSB byte cycles with programmable setup/strobe/hold timing.
module xosera_bus_sequencer #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_rd_nwr_i,
  input  logic        cmd_8bit_i,
  input  logic [3:0]  cmd_reg_i,
  input  logic [15:0] cmd_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        busy_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  input  logic [7:0]  bus_data_i
);

  localparam int MAXP = (SETUP_CYCLES > STROBE_CYCLES) ?
                        ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                        ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CW = (MAXP < 1) ? 1 : $clog2(MAXP + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          w_cnt_done;
  logic          r_idx;
  logic          r_rd_nwr;
  logic [15:0]   r_data;
  logic [7:0]    r_msb;
  logic [7:0]    r_lsb;
  logic          r_rsp_valid;
  logic [15:0]   r_rsp_data;
  logic          r_cs_n;
  logic          r_bus_rd_nwr;
  logic [3:0]    r_bus_reg;
  logic          r_bus_bytesel;
  logic [7:0]    r_bus_data;

  assign w_cnt_done = (r_cnt == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid_i) w_next = S_SETUP;
      S_SETUP:  if (w_cnt_done) w_next = S_STROBE;
      S_STROBE: if (w_cnt_done) w_next = S_HOLD;
      S_HOLD:   if (w_cnt_done) w_next = r_idx ? S_IDLE : S_SETUP;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus outputs are registered and only change on state transitions, so
  // address/data move exclusively at SETUP entry while cs_n is high.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= 1'b0;
      r_rd_nwr      <= 1'b1;
      r_data        <= '0;
      r_msb         <= '0;
      r_lsb         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_cs_n        <= 1'b1;
      r_bus_rd_nwr  <= 1'b1;
      r_bus_reg     <= '0;
      r_bus_bytesel <= 1'b0;
      r_bus_data    <= '0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= 1'b0;

      if (w_next != r_state) begin
        case (w_next)
          S_SETUP:  r_cnt <= CW'(SETUP_CYCLES - 1);
          S_STROBE: r_cnt <= CW'(STROBE_CYCLES - 1);
          S_HOLD:   r_cnt <= CW'(HOLD_CYCLES - 1);
          default:  r_cnt <= '0;
        endcase
      end else if (!w_cnt_done) begin
        r_cnt <= r_cnt - 1'b1;
      end

      case (r_state)
        S_IDLE: if (cmd_valid_i) begin
          r_idx         <= cmd_8bit_i;
          r_rd_nwr      <= cmd_rd_nwr_i;
          r_data        <= cmd_data_i;
          r_msb         <= '0;
          r_bus_reg     <= cmd_reg_i;
          r_bus_rd_nwr  <= cmd_rd_nwr_i;
          r_bus_bytesel <= cmd_8bit_i;
          r_bus_data    <= cmd_8bit_i ? cmd_data_i[7:0] : cmd_data_i[15:8];
        end
        S_SETUP: if (w_cnt_done) r_cs_n <= 1'b0;
        S_STROBE: if (w_cnt_done) begin
          r_cs_n <= 1'b1;
          if (r_rd_nwr) begin
            if (r_idx) r_lsb <= bus_data_i;
            else       r_msb <= bus_data_i;
          end
        end
        S_HOLD: if (w_cnt_done) begin
          if (!r_idx) begin
            r_idx         <= 1'b1;
            r_bus_bytesel <= 1'b1;
            r_bus_data    <= r_data[7:0];
          end else begin
            r_rsp_valid  <= 1'b1;
            r_bus_rd_nwr <= 1'b1;
            if (r_rd_nwr) r_rsp_data <= {r_msb, r_lsb};
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready_o   = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_data_o    = r_rsp_data;
  assign bus_cs_n_o    = r_cs_n;
  assign bus_rd_nwr_o  = r_bus_rd_nwr;
  assign bus_reg_num_o = r_bus_reg;
  assign bus_bytesel_o = r_bus_bytesel;
  assign bus_data_o    = r_bus_data;

endmodule

// File: tb/tb_xosera_bus_sequencer.sv
// Directed bench for xosera_bus_sequencer: default timing instance plus a
// SETUP=2/STROBE=3/HOLD=2 instance, per-cycle bus pattern checks.
module tb_xosera_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid1, valid2;
  logic        rd, b8;
  logic [3:0]  rg;
  logic [15:0] dat;
  logic [7:0]  msb_b, lsb_b;
  logic [7:0]  bus_in1, bus_in2;

  logic        rdy1, rv1, busy1, cs1, rdn1, bs1;
  logic [15:0] rsp1;
  logic [3:0]  reg1;
  logic [7:0]  bd1;
  logic        rdy2, rv2, busy2, cs2, rdn2, bs2;
  logic [15:0] rsp2;
  logic [3:0]  reg2;
  logic [7:0]  bd2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign bus_in1 = bs1 ? lsb_b : msb_b;
  assign bus_in2 = 8'h00;

  xosera_bus_sequencer dut1 (
    .clk(clk), .reset_n_i(rst_n),
    .cmd_valid_i(valid1), .cmd_ready_o(rdy1), .cmd_rd_nwr_i(rd), .cmd_8bit_i(b8),
    .cmd_reg_i(rg), .cmd_data_i(dat),
    .rsp_valid_o(rv1), .rsp_data_o(rsp1), .busy_o(busy1),
    .bus_cs_n_o(cs1), .bus_rd_nwr_o(rdn1), .bus_reg_num_o(reg1),
    .bus_bytesel_o(bs1), .bus_data_o(bd1), .bus_data_i(bus_in1)
  );

  xosera_bus_sequencer #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) dut2 (
    .clk(clk), .reset_n_i(rst_n),
    .cmd_valid_i(valid2), .cmd_ready_o(rdy2), .cmd_rd_nwr_i(rd), .cmd_8bit_i(b8),
    .cmd_reg_i(rg), .cmd_data_i(dat),
    .rsp_valid_o(rv2), .rsp_data_o(rsp2), .busy_o(busy2),
    .bus_cs_n_o(cs2), .bus_rd_nwr_o(rdn2), .bus_reg_num_o(reg2),
    .bus_bytesel_o(bs2), .bus_data_o(bd2), .bus_data_i(bus_in2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Issue a command at the current cycle (cycle 0) and check every following
  // cycle up to IDLE re-entry at cycle n. ecs/ebs hold expected cs_n/bytesel
  // per cycle, bit index = cycle number.
  task automatic do_cmd(input bit sel, input bit keep, input logic r, input logic e8,
                        input logic [3:0] g, input logic [15:0] d, input int n,
                        input logic [15:0] ecs, input logic [15:0] ebs);
    logic o_cs, o_bs, o_rdn, o_busy, o_rv;
    logic [3:0] o_reg;
    logic [7:0] o_bd;
    chk("ready_at_accept", sel ? rdy2 : rdy1, 1);
    rd = r; b8 = e8; rg = g; dat = d;
    if (sel) valid2 = 1'b1; else valid1 = 1'b1;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (c == 1) begin
        dat = ~d;
        if (!keep) begin valid1 = 1'b0; valid2 = 1'b0; end
      end
      o_cs   = sel ? cs2   : cs1;
      o_bs   = sel ? bs2   : bs1;
      o_rdn  = sel ? rdn2  : rdn1;
      o_busy = sel ? busy2 : busy1;
      o_rv   = sel ? rv2   : rv1;
      o_reg  = sel ? reg2  : reg1;
      o_bd   = sel ? bd2   : bd1;
      if (c < n) begin
        chk("cs_n", o_cs, ecs[c]);
        chk("bytesel", o_bs, ebs[c]);
        chk("reg_num", o_reg, g);
        chk("rd_nwr", o_rdn, r);
        chk("busy", o_busy, 1);
        chk("rsp_valid_early", o_rv, 0);
        if (!r) chk("wdata", o_bd, ebs[c] ? d[7:0] : d[15:8]);
      end else begin
        chk("rsp_valid", o_rv, 1);
        chk("busy_end", o_busy, 0);
        chk("cs_n_idle", o_cs, 1);
        chk("rd_nwr_idle", o_rdn, 1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
    rd = 1'b0; b8 = 1'b0; rg = 4'h0; dat = 16'h0000;
    msb_b = 8'h00; lsb_b = 8'h00;
    tick();
    chk("rst_ready", rdy1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_rsp_valid", rv1, 0);
    chk("rst_rsp_data", rsp1, 16'h0000);
    chk("rst_cs_n", cs1, 1);
    chk("rst_rd_nwr", rdn1, 1);
    chk("rst_reg", reg1, 4'h0);
    chk("rst_bytesel", bs1, 0);
    chk("rst_data", bd1, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // 16-bit write reg 3 = ABCD: strobes in cycles 2-3 and 6-7, IDLE at 9
    do_cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 16'hABCD, 9, 16'h0132, 16'h01E0);
    chk("rsp_data_after_write", rsp1, 16'h0000);
    tick();
    chk("rsp_valid_one_cycle", rv1, 0);
    chk("bytesel_kept_idle", bs1, 1);
    chk("data_kept_idle", bd1, 8'hCD);

    // 16-bit read, MSB 12 / LSB 34
    msb_b = 8'h12; lsb_b = 8'h34;
    do_cmd(1'b0, 1'b0, 1'b1, 1'b0, 4'h7, 16'h0000, 9, 16'h0132, 16'h01E0);
    chk("rd16_data", rsp1, 16'h1234);
    tick();
    chk("rd16_data_hold", rsp1, 16'h1234);

    // 8-bit read: LSB only, MSB lane must not leak into the response
    msb_b = 8'hEE; lsb_b = 8'h5A;
    do_cmd(1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 16'h0000, 5, 16'h0012, 16'h001E);
    chk("rd8_data", rsp1, 16'h005A);
    tick();

    // Back-to-back writes with valid held: second accepted in completion cycle
    do_cmd(1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 16'h1122, 9, 16'h0132, 16'h01E0);
    do_cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 16'h3344, 9, 16'h0132, 16'h01E0);
    chk("b2b_rsp_data_unchanged", rsp1, 16'h005A);
    tick();

    // Slow-timing instance: 14-cycle command, strobe width 3
    do_cmd(1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 16'hC3A5, 15, 16'h63C6, 16'h7F00);
    tick();

    // Reset asserted mid-strobe of the first byte
    rd = 1'b0; b8 = 1'b0; rg = 4'h6; dat = 16'hBEEF; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    tick();
    chk("pre_reset_strobe", cs1, 0);
    rst_n = 1'b0;
    #1;
    chk("reset_cs_n_immediate", cs1, 1);
    chk("reset_ready", rdy1, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("reset_no_rsp", rv1, 0);
    end
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", rdy1, 1);
    chk("post_reset_busy", busy1, 0);
    chk("post_reset_rsp_data", rsp1, 16'h0000);
    do_cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 16'h0F0F, 9, 16'h0132, 16'h01E0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
